// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared address type and next-PC select encoding
package cpu_pkg;
  localparam int ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    PC_SRC_INC    = 1'b0,
    PC_SRC_BRANCH = 1'b1
  } pc_src_e;
endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - combinational next-PC: sequential increment or PC-relative branch
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] immediate,
  input  pc_src_e          pc_src,
  output logic [WIDTH-1:0] pc_next
);

  // Two's-complement offset needs no sign handling: modulo-2^WIDTH add does it.
  always_comb begin
    pc_next = pc + WIDTH'(1);
    if (pc_src == PC_SRC_BRANCH) begin
      pc_next = pc + immediate;
    end
  end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with synchronous reset; next value from pc_next_logic
module program_counter
  import cpu_pkg::*;
#(
  parameter int               WIDTH      = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic [WIDTH-1:0] immediate,
  input  logic             PCSrc,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] PC
);

  logic [WIDTH-1:0] pc_next;

  pc_next_logic #(
    .WIDTH(WIDTH)
  ) u_pc_next_logic (
    .pc       (PC),
    .immediate(immediate),
    .pc_src   (pc_src_e'(PCSrc)),
    .pc_next  (pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= RESET_ADDR;
    end else begin
      PC <= pc_next;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed and randomized checks of program_counter against an integer model
module tb_program_counter;

  logic [7:0] immediate;
  logic       PCSrc;
  logic       clk;
  logic       reset;
  logic [7:0] PC;

  int checks = 0;
  int passed = 0;
  int model_pc = 0;

  program_counter dut (
    .immediate(immediate),
    .PCSrc    (PCSrc),
    .clk      (clk),
    .reset    (reset),
    .PC       (PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] observed, input int expected);
    logic [7:0] exp8;
    exp8 = expected[7:0];
    checks++;
    assert (observed === exp8) passed++;
    else $error("FAIL %s: PC=%0h expected %0h", name, observed, exp8);
  endtask

  // Address space is the integers 0..255; the immediate is a signed offset -128..127.
  task automatic model_edge(input logic r, input logic src, input logic [7:0] imm);
    int offset;
    if (r) begin
      model_pc = 0;
    end else begin
      offset = src ? ((int'(imm) > 127) ? int'(imm) - 256 : int'(imm)) : 1;
      model_pc = (((model_pc + offset) % 256) + 256) % 256;
    end
  endtask

  task automatic step(input logic r, input logic src, input logic [7:0] imm,
                      input int expected, input string name);
    reset = r;
    PCSrc = src;
    immediate = imm;
    @(posedge clk);
    model_edge(r, src, imm);
    #1;
    check(name, PC, expected);
    check({name, "_model"}, PC, model_pc);
  endtask

  initial begin
    reset = 1'b1;
    PCSrc = 1'b0;
    immediate = 8'h01;
    @(negedge clk);

    step(1, 0, 8'h01, 0, "reset_first");
    for (int i = 0; i < 3; i++) step(1, 0, 8'h01, 0, "reset_hold");

    step(0, 1, 8'h01, 1, "branch_p1_a");
    step(0, 1, 8'h01, 2, "branch_p1_b");
    step(0, 1, 8'h07, 9, "branch_p7_a");
    step(0, 1, 8'h07, 16, "branch_p7_b");

    step(0, 0, 8'h07, 17, "seq_a");
    step(0, 0, 8'h07, 18, "seq_b");
    step(0, 0, 8'h07, 19, "seq_c");
    step(0, 1, 8'hFF, 18, "branch_m1");

    // Reset raised between edges must not touch PC until the next rising edge.
    reset = 1'b1;
    #3;
    check("reset_not_async", PC, 18);
    step(1, 0, 8'h00, 0, "reset_mid_run");
    step(1, 1, 8'h05, 0, "reset_beats_branch");

    step(0, 1, 8'hFF, 8'hFF, "to_ff");
    step(0, 0, 8'h00, 0, "inc_wrap");
    step(0, 1, 8'h0A, 10, "to_10");
    step(0, 1, 8'hFE, 8, "branch_m2");
    step(1, 0, 8'h00, 0, "reset_again");
    step(0, 0, 8'h00, 1, "inc_from_reset");
    step(0, 1, 8'hFD, 8'hFE, "branch_wrap_below_0");
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 8'hFE, "self_loop");

    for (int i = 0; i < 300; i++) begin
      reset = ($urandom_range(0, 15) == 0);
      PCSrc = 1'($urandom_range(0, 1));
      immediate = 8'($urandom_range(0, 255));
      @(posedge clk);
      model_edge(reset, PCSrc, immediate);
      #1;
      check("random", PC, model_pc);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
